// File: rtl/prescale_cnt_pkg.sv
// prescale_cnt_pkg: shared constants for the prescaled modulo counter.
package prescale_cnt_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam logic [31:0] DIV_50MHZ_1HZ = 32'd50_000_000;
endpackage

// File: rtl/prescale_cnt_tick_gen.sv
// tick_gen: clock-enable prescaler issuing one step every num enabled cycles.
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  input  logic             en,
  input  logic             clr,
  output logic             step
);
  logic [DIV_W-1:0] pre_cnt;
  // >= rather than == so a shrinking num takes effect immediately
  assign step = en & ~clr & ((num <= DIV_W'(1)) | (pre_cnt >= num - DIV_W'(1)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre_cnt <= '0;
    else pre_cnt <= (clr | step) ? '0 : en ? pre_cnt + DIV_W'(1) : pre_cnt;
endmodule

// File: rtl/prescale_cnt.sv
// prescale_cnt: WIDTH-bit 0..MAX counter stepped by a built-in prescaler.
module prescale_cnt
  import prescale_cnt_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX = 59,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
  logic s, at_edge, tc_d;
  logic [WIDTH-1:0] out_d, edge_val;
  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .num(num), .en(en), .clr(load), .step(s)
  );
  always_comb begin
    at_edge = (up == DIR_UP) ? (out >= TOP) : (out == '0);
    edge_val = (mode == MODE_SAT) ? ((up == DIR_UP) ? TOP : '0) : ((up == DIR_UP) ? '0 : TOP);
    out_d = out;
    tc_d = 1'b0;
    if (load) out_d = (load_val > TOP) ? TOP : load_val;
    else if (s) begin
      tc_d = at_edge;
      out_d = at_edge ? edge_val : (up == DIR_UP) ? out + WIDTH'(1) : out - WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= '0;
      tick <= 1'b0;
      tc <= 1'b0;
    end else begin
      out <= out_d;
      tick <= s;
      tc <= tc_d;
    end
endmodule

// File: tb/tb_prescale_cnt.sv
// tb_prescale_cnt: random and directed stimulus against an integer reference model.
module tb_prescale_cnt;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] num = 32'd4;
  logic en = 1'b0, up = 1'b1, mode = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] out;
  logic tick, tc;
  int checks = 0, errors = 0;
  longint m_pre = 0;
  int m_out = 0;
  bit m_tick = 0, m_tc = 0;
  localparam int MAXV = 59;

  prescale_cnt #(.WIDTH(6), .MAX(MAXV), .DIV_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .out(out), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock edge: advance the model from the sampled inputs, then compare
  task automatic cyc();
    bit s;
    int nxt;
    @(posedge clk);
    if (!rst_n) begin
      m_pre = 0; m_out = 0; m_tick = 0; m_tc = 0;
    end else begin
      s = en && !load && (longint'(num) <= 1 || m_pre >= longint'(num) - 1);
      m_pre = (load || s) ? 0 : en ? m_pre + 1 : m_pre;
      m_tick = s;
      m_tc = 0;
      if (load) m_out = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      else if (s) begin
        nxt = up ? m_out + 1 : m_out - 1;
        if (nxt > MAXV || nxt < 0) begin
          m_tc = 1;
          m_out = mode ? (up ? MAXV : 0) : (up ? 0 : MAXV);
        end else m_out = nxt;
      end
    end
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tc", 32'(tc), 32'(m_tc));
  endtask

  task automatic do_load(input logic [5:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #2 chk("reset_out", 32'(out), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    // count up with num=4 through the wrap at 59
    num = 4; en = 1; up = 1; mode = 0;
    repeat (4 * 62) cyc();
    // saturation at the top, then count back down
    num = 1; mode = 1;
    do_load(6'd57);
    repeat (4) cyc();
    chk("sat_out", 32'(out), 32'd59);
    chk("sat_tc", 32'(tc), 32'd1);
    up = 0;
    repeat (2) cyc();
    chk("sat_down", 32'(out), 32'd57);
    // down wrap from zero, then an out-of-range load
    mode = 0;
    do_load(6'd0);
    cyc();
    chk("dwrap_out", 32'(out), 32'd59);
    chk("dwrap_tc", 32'(tc), 32'd1);
    do_load(6'd63);
    chk("clamp_out", 32'(out), 32'd59);
    chk("clamp_tick", 32'(tick), 32'd0);
    // enable gap with num=10
    num = 10; up = 1;
    do_load(6'd5);
    repeat (6) cyc();
    en = 0;
    repeat (5) cyc();
    en = 1;
    repeat (3) cyc();
    chk("gap_notick", 32'(tick), 32'd0);
    cyc();
    chk("gap_tick", 32'(tick), 32'd1);
    // shrinking num mid-count
    do_load(6'd10);
    repeat (7) cyc();
    num = 3;
    cyc();
    chk("shrink_tick", 32'(tick), 32'd1);
    chk("shrink_out", 32'(out), 32'd11);
    // async reset between edges
    num = 5;
    repeat (3) cyc();
    #2 rst_n = 0;
    #1 chk("areset_out", 32'(out), 32'd0);
    chk("areset_tick", 32'(tick), 32'd0);
    chk("areset_tc", 32'(tc), 32'd0);
    m_pre = 0; m_out = 0; m_tick = 0; m_tc = 0;
    @(negedge clk) rst_n = 1;
    repeat (4) cyc();
    chk("rel_notick", 32'(tick), 32'd0);
    cyc();
    chk("rel_tick", 32'(tick), 32'd1);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      load_val = 6'($urandom);
      if ($urandom_range(0, 19) == 0) num = $urandom_range(0, 5);
      if ($urandom_range(0, 49) == 0) up = ~up;
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prescale_cnt.md
# prescale_cnt

Parametrised modulo counter with a built-in clock-enable prescaler. It generalises the fixed 6-bit counter and divider pair into one block with configurable width, modulus, direction, wrap/saturate mode, synchronous load and enable. Used wherever a slow, human-visible count is derived from the 50 MHz system clock, such as seconds/minutes displays and LED sequencers.

## Interface
Parameters:
- WIDTH, 6, counter width in bits
- MAX, 59, terminal count (count range 0..MAX); MAX ≤ 2^WIDTH−1
- DIV_W, 32, prescale period width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- num  in  DIV_W  prescale period N (clk cycles per count step); 0 and 1 both mean every cycle
- en  in  1  count enable; 0 freezes prescaler and counter
- up  in  1  direction: 1 up, 0 down
- mode  in  1  0 wrap, 1 saturate
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load=1
- out  out  WIDTH  current count
- tick  out  1  one-cycle pulse, high in the cycle where out shows a newly stepped value
- tc  out  1  one-cycle pulse, high when that step hit the range boundary

## Operation
- Reset (rst_n=0, asynchronous): pre_cnt=0, out=0, tick=0, tc=0.
- Step condition s = en & ~load & (num≤1 | pre_cnt ≥ num−1). The ≥ makes shrinking num mid-count take effect at the next edge, with no 2^DIV_W run-out.
- Prescaler: if load, pre_cnt←0. Else if s, pre_cnt←0. Else if en, pre_cnt←pre_cnt+1. Else it holds.
- Counter priority: load > step > hold.
  - load: out←min(load_val, MAX); tick←0; tc←0.
  - step, up=1: if out≥MAX, out←0 (mode 0) or MAX (mode 1) and tc←1. Otherwise out←out+1 and tc←0.
  - step, up=0: if out==0, out←MAX (mode 0) or 0 (mode 1) and tc←1. Otherwise out←out−1 and tc←0.
  - tick←s on every edge.
- In saturate mode, tc keeps pulsing on every step while the counter is pinned at the boundary.
- Changes to up, mode or num take effect on the next edge. No state is flushed.
- Arithmetic is at WIDTH bits. out never leaves 0..MAX.

## Timing
- All outputs are registered. tick, tc and the new out value appear together, one cycle after the edge where s is sampled true.
- With en held high from pre_cnt=0 and num=N≥1, out steps on the Nth, 2Nth, … rising edge. tick is high for exactly 1 of every N cycles.
- num≤1: out steps every cycle and tick stays high continuously.
- en falling: no step at that edge, and pre_cnt holds its value. When en rises again, counting resumes from the held pre_cnt.
- load during en: applied at that edge. The prescaler restarts, so the next step comes N edges later.
- Reset mid-operation clears everything immediately, with no clock needed. The first step after release is at edge N.

## Structure
- Shared package prescale_cnt_pkg holds these constants:
  - MODE_WRAP=1'b0, MODE_SAT=1'b1
  - DIR_DOWN=1'b0, DIR_UP=1'b1
  - default DIV_50MHZ_1HZ=32'd50_000_000
- Sub-module tick_gen (ports clk, rst_n, num, en, clr, step) contains pre_cnt and the step decode.
- The top level holds the counter, the boundary logic and the output registers.

## Test plan
- Reset then num=4, en=1, up=1, mode=0, MAX=59: tick pulses every 4th cycle. out reads 0,1,2,… one per tick. At 59 the next tick gives out=0 with tc=1 in the same cycle.
- Saturation, num=1, up=1, mode=1, load_val=57 loaded: out reads 58, 59, 59, 59. tc is high on each step at 59. Then set up=0 and out goes 58, 57 with tc=0.
- Down wrap, num=1, up=0, mode=0, out=0: the next step gives out=59 and tc=1. Load load_val=63 (>MAX): out=59 with tick=0 and tc=0 in that cycle.
- Enable and num change, num=10: drop en after 6 cycles for 5 cycles, then restore. The first step comes 4 cycles after en returns. Set num=3 while pre_cnt=7: a step occurs at the next edge.
- Async reset: assert rst_n=0 mid-count between clock edges. out, tick, tc and pre_cnt go to 0 immediately. After release with num=5, the first tick comes at edge 5.
